// File: rtl/dcache_tag_array.sv
// dcache_tag_array: tag/valid/dirty store for the non-blocking L1 data cache.
// Port 0 (miss handler) has fixed priority; ports 1..NR_PORTS-1 share a
// round-robin slot. Reads return all ways one cycle after grant together with
// a tag compare. A post-reset init sweep and an on-demand invalidate-all sweep
// clear valid/dirty one set per cycle, leaving tags untouched.
module dcache_tag_array #(
  parameter int unsigned NR_PORTS    = 4,
  parameter int unsigned SET_ASSOC   = 8,
  parameter int unsigned INDEX_WIDTH = 12,
  parameter int unsigned LINE_OFFSET = 4,
  parameter int unsigned TAG_WIDTH   = 44
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NR_PORTS-1:0][SET_ASSOC-1:0]        req_i,
  input  logic [NR_PORTS-1:0][INDEX_WIDTH-1:0]      addr_i,
  input  logic [NR_PORTS-1:0]                       we_i,
  input  logic [NR_PORTS-1:0][1:0]                  be_i,
  input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]        wtag_i,
  input  logic [NR_PORTS-1:0]                       wvalid_i,
  input  logic [NR_PORTS-1:0]                       wdirty_i,
  input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]        tag_i,
  output logic [NR_PORTS-1:0]                       gnt_o,
  output logic [NR_PORTS-1:0]                       rvalid_o,
  output logic [SET_ASSOC-1:0][TAG_WIDTH-1:0]       rtag_o,
  output logic [SET_ASSOC-1:0]                      rvalid_bits_o,
  output logic [SET_ASSOC-1:0]                      rdirty_o,
  output logic [SET_ASSOC-1:0]                      hit_way_o,
  input  logic                                      inval_i,
  output logic                                      inval_ack_o,
  output logic                                      busy_o
);

  localparam int unsigned SET_W    = INDEX_WIDTH - LINE_OFFSET;
  localparam int unsigned NUM_SETS = 2 ** SET_W;
  localparam int unsigned PORT_W   = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam logic [SET_W-1:0]  LAST_SET  = '1;
  localparam logic [PORT_W-1:0] FIRST_RR  = PORT_W'(1);
  localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NR_PORTS - 1);

  typedef enum logic [1:0] {INIT, IDLE, SWEEP, ACK} state_e;

  state_e                             state_q, state_d;
  logic [SET_W-1:0]                   cnt_q, cnt_d;
  logic [PORT_W-1:0]                  rr_q, rr_d;
  logic [NR_PORTS-1:0]                rvalid_q;

  logic [SET_ASSOC-1:0][TAG_WIDTH-1:0] tag_mem   [NUM_SETS];
  logic [SET_ASSOC-1:0]                valid_mem [NUM_SETS];
  logic [SET_ASSOC-1:0]                dirty_mem [NUM_SETS];

  logic [SET_ASSOC-1:0][TAG_WIDTH-1:0] rtag_q;
  logic [SET_ASSOC-1:0]                rvb_q;
  logic [SET_ASSOC-1:0]                rdirty_q;

  logic [NR_PORTS-1:0]  port_req;
  logic [PORT_W-1:0]    gidx;
  logic [PORT_W-1:0]    cand;
  logic                 granted;
  logic [SET_W-1:0]     gset;
  logic                 sweep_we;
  logic                 wr_en;
  logic                 rd_en;
  logic [TAG_WIDTH-1:0] cmp_tag;
  logic                 unused_offset;

  // Line-offset address bits carry no information for a tag lookup.
  assign unused_offset = ^addr_i;

  // A port requests whenever any of its way-select bits is set.
  always_comb begin
    port_req = '0;
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      port_req[p] = |req_i[p];
    end
  end

  // Arbitration: port 0 first, then round-robin over 1..NR_PORTS-1 from rr_q.
  // A pending invalidate blocks every grant so the sweep can start promptly.
  always_comb begin
    gnt_o   = '0;
    gidx    = '0;
    cand    = '0;
    granted = 1'b0;
    if (state_q == IDLE && !inval_i) begin
      if (port_req[0]) begin
        granted = 1'b1;
      end else begin
        for (int unsigned k = 0; k < NR_PORTS - 1; k++) begin
          cand = PORT_W'(((32'(rr_q) - 32'd1 + k) % (NR_PORTS - 1)) + 1);
          if (!granted && port_req[cand]) begin
            granted = 1'b1;
            gidx    = cand;
          end
        end
      end
      if (granted) gnt_o[gidx] = 1'b1;
    end
  end

  assign gset     = addr_i[gidx][INDEX_WIDTH-1:LINE_OFFSET];
  assign wr_en    = granted & we_i[gidx];
  assign rd_en    = granted & ~we_i[gidx];
  assign sweep_we = (state_q == INIT) || (state_q == SWEEP);
  assign busy_o      = sweep_we;
  assign inval_ack_o = (state_q == ACK);

  // Next-state, sweep counter and round-robin pointer update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_SET) state_d = IDLE;
      end
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_SET) state_d = ACK;
      end
      ACK: state_d = IDLE;
      IDLE: begin
        if (inval_i && (rvalid_q == '0)) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
        if (granted && (gidx != '0)) begin
          rr_d = (gidx == LAST_PORT) ? FIRST_RR : gidx + 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Control state and registered read outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      rr_q     <= FIRST_RR;
      rvalid_q <= '0;
      rtag_q   <= '0;
      rvb_q    <= '0;
      rdirty_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      rvalid_q <= rd_en ? gnt_o : '0;
      if (rd_en) begin
        rtag_q   <= tag_mem[gset];
        rvb_q    <= valid_mem[gset];
        rdirty_q <= dirty_mem[gset];
      end
    end
  end

  // SRAM-style storage: sweep clears one set per cycle, else the granted write.
  always_ff @(posedge clk_i) begin
    if (sweep_we) begin
      valid_mem[cnt_q] <= '0;
      dirty_mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int unsigned w = 0; w < SET_ASSOC; w++) begin
        if (req_i[gidx][w]) begin
          if (be_i[gidx][0]) tag_mem[gset][w] <= wtag_i[gidx];
          if (be_i[gidx][1]) begin
            valid_mem[gset][w] <= wvalid_i[gidx];
            dirty_mem[gset][w] <= wdirty_i[gidx];
          end
        end
      end
    end
  end

  // Hit compare against the live tag_i of whichever port owns the response.
  always_comb begin
    cmp_tag   = '0;
    hit_way_o = '0;
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      if (rvalid_q[p]) cmp_tag = cmp_tag | tag_i[p];
    end
    for (int unsigned w = 0; w < SET_ASSOC; w++) begin
      hit_way_o[w] = (|rvalid_q) & rvb_q[w] & (rtag_q[w] == cmp_tag);
    end
  end

  assign rvalid_o      = rvalid_q;
  assign rtag_o        = rtag_q;
  assign rvalid_bits_o = rvb_q;
  assign rdirty_o      = rdirty_q;

endmodule
